// File: rtl/pack_data.sv
// Serial-to-parallel packer: gathers NB_DATA-bit samples into an N_LENGTH_DATA-lane word.
// Optional partial-word flush (i_flush / o_count) is built when PACK_FLUSH_EN is defined.
module pack_data #(
    parameter int NB_DATA       = 8,
    parameter int N_LENGTH_DATA = 8
) (
    input  logic                               clock,
    input  logic                               i_reset,
    input  logic [NB_DATA-1:0]                 i_data,
    input  logic                               i_valid,
    output logic                               o_ready,
    output logic [NB_DATA*N_LENGTH_DATA-1:0]   o_data,
    output logic                               o_valid,
    input  logic                               i_ready
`ifdef PACK_FLUSH_EN
    ,
    input  logic                               i_flush,
    output logic [$clog2(N_LENGTH_DATA):0]     o_count
`endif
);

    localparam int CW = $clog2(N_LENGTH_DATA);
    localparam int WW = NB_DATA * N_LENGTH_DATA;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [WW-1:0]   data_q;
    logic [WW-1:0]   data_next;
    logic            accept;
    logic            last;
`ifdef PACK_FLUSH_EN
    logic [CW:0]     count_q;
    logic [CW:0]     count_next;
`endif

    assign accept = i_valid && (state == FILL);
    assign last   = (cnt == CW'(N_LENGTH_DATA - 1));

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
`ifdef PACK_FLUSH_EN
            count_q <= '0;
`endif
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            data_q <= data_next;
`ifdef PACK_FLUSH_EN
            count_q <= count_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        data_next  = data_q;
`ifdef PACK_FLUSH_EN
        count_next = count_q;
`endif
        case (state)
            FILL: begin
                if (accept) begin
                    data_next[int'(cnt)*NB_DATA +: NB_DATA] = i_data;
                    if (last) begin
                        cnt_next   = '0;
                        state_next = FULL;
`ifdef PACK_FLUSH_EN
                        count_next = (CW+1)'(N_LENGTH_DATA);
`endif
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
`ifdef PACK_FLUSH_EN
                // Flush closes a partial word; a sample taken on the same edge still counts.
                if (i_flush && !(accept && last) && ((cnt != '0) || accept)) begin
                    cnt_next   = '0;
                    state_next = FULL;
                    count_next = {1'b0, cnt} + (CW+1)'(accept);
                end
`endif
            end
            FULL: begin
                if (i_ready) begin
                    state_next = FILL;
                    data_next  = '0;
`ifdef PACK_FLUSH_EN
                    count_next = '0;
`endif
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = '0;
                data_next  = '0;
            end
        endcase
    end

    assign o_ready = (state == FILL);
    assign o_valid = (state == FULL);
    assign o_data  = data_q;
`ifdef PACK_FLUSH_EN
    assign o_count = count_q;
`endif

endmodule

// File: tb/tb_pack_data.sv
// Directed, table-driven bench for pack_data (8x8 instance plus a 3x4 instance).
// Flush checks are compiled in when PACK_FLUSH_EN is defined.
module tb_pack_data;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_out;
    logic [63:0] data_out;
    logic        valid_out;
    logic        ready_in;
`ifdef PACK_FLUSH_EN
    logic        flush;
    logic [3:0]  count;
`endif

    logic        reset3;
    logic [3:0]  data_in3;
    logic        valid_in3;
    logic        ready_out3;
    logic [11:0] data_out3;
    logic        valid_out3;
    logic        ready_in3;
`ifdef PACK_FLUSH_EN
    logic        flush3;
    logic [2:0]  count3;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pack_data #(.NB_DATA(8), .N_LENGTH_DATA(8)) dut (
        .clock   (clock),
        .i_reset (reset),
        .i_data  (data_in),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .o_data  (data_out),
        .o_valid (valid_out),
        .i_ready (ready_in)
`ifdef PACK_FLUSH_EN
        ,
        .i_flush (flush),
        .o_count (count)
`endif
    );

    pack_data #(.NB_DATA(4), .N_LENGTH_DATA(3)) dut3 (
        .clock   (clock),
        .i_reset (reset3),
        .i_data  (data_in3),
        .i_valid (valid_in3),
        .o_ready (ready_out3),
        .o_data  (data_out3),
        .o_valid (valid_out3),
        .i_ready (ready_in3)
`ifdef PACK_FLUSH_EN
        ,
        .i_flush (flush3),
        .o_count (count3)
`endif
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        ev;
        logic        er;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rst, logic v, logic [7:0] d, logic rdy,
                                logic ev, logic er, logic [63:0] ed);
        vec_t x;
        x.rst = rst; x.v = v; x.d = d; x.rdy = rdy;
        x.ev = ev; x.er = er; x.ed = ed;
        vecs.push_back(x);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(logic rst, logic v, logic [7:0] d, logic rdy);
        @(negedge clock);
        reset = rst; valid_in = v; data_in = d; ready_in = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic step3(logic rst, logic v, logic [3:0] d, logic rdy);
        @(negedge clock);
        reset3 = rst; valid_in3 = v; data_in3 = d; ready_in3 = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(string name, logic ev, logic er, logic [63:0] ed);
        check({name, ".valid"}, {63'd0, valid_out}, {63'd0, ev});
        check({name, ".ready"}, {63'd0, ready_out}, {63'd0, er});
        check({name, ".data"}, data_out, ed);
    endtask

    task automatic check_out3(string name, logic ev, logic er, logic [11:0] ed);
        check({name, ".valid"}, {63'd0, valid_out3}, {63'd0, ev});
        check({name, ".ready"}, {63'd0, ready_out3}, {63'd0, er});
        check({name, ".data"}, {52'd0, data_out3}, {52'd0, ed});
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
        reset3 = 1'b1; valid_in3 = 1'b0; data_in3 = '0; ready_in3 = 1'b0;
`ifdef PACK_FLUSH_EN
        flush = 1'b0; flush3 = 1'b0;
`endif

        // Continuous stream 01..08 with downstream always ready.
        add(1, 1, 8'hEE, 1, 0, 1, 64'h0);
        add(0, 1, 8'h01, 1, 0, 1, 64'h01);
        add(0, 1, 8'h02, 1, 0, 1, 64'h0201);
        add(0, 1, 8'h03, 1, 0, 1, 64'h030201);
        add(0, 1, 8'h04, 1, 0, 1, 64'h04030201);
        add(0, 1, 8'h05, 1, 0, 1, 64'h0504030201);
        add(0, 1, 8'h06, 1, 0, 1, 64'h060504030201);
        add(0, 1, 8'h07, 1, 0, 1, 64'h07060504030201);
        add(0, 1, 8'h08, 1, 1, 0, 64'h0807060504030201);
        add(0, 1, 8'h55, 1, 0, 1, 64'h0);
        add(0, 0, 8'h66, 1, 0, 1, 64'h0);
        // Partial word discarded by reset, then a fresh word from lane 0.
        add(0, 1, 8'hFF, 1, 0, 1, 64'hFF);
        add(0, 1, 8'hFF, 1, 0, 1, 64'hFFFF);
        add(0, 1, 8'hFF, 1, 0, 1, 64'hFFFFFF);
        add(1, 1, 8'h77, 1, 0, 1, 64'h0);
        add(0, 1, 8'h10, 0, 0, 1, 64'h10);
        add(0, 1, 8'h11, 0, 0, 1, 64'h1110);
        add(0, 1, 8'h12, 0, 0, 1, 64'h121110);
        add(0, 1, 8'h13, 0, 0, 1, 64'h13121110);
        add(0, 1, 8'h14, 0, 0, 1, 64'h1413121110);
        add(0, 1, 8'h15, 0, 0, 1, 64'h151413121110);
        add(0, 1, 8'h16, 0, 0, 1, 64'h16151413121110);
        add(0, 1, 8'h17, 0, 1, 0, 64'h1716151413121110);
        add(0, 0, 8'h00, 1, 0, 1, 64'h0);
        // Toggling valid: only the A0..A7 cycles are accepted.
        add(0, 1, 8'hA0, 0, 0, 1, 64'hA0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA0);
        add(0, 1, 8'hA1, 0, 0, 1, 64'hA1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA1A0);
        add(0, 1, 8'hA2, 0, 0, 1, 64'hA2A1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA2A1A0);
        add(0, 1, 8'hA3, 0, 0, 1, 64'hA3A2A1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA3A2A1A0);
        add(0, 1, 8'hA4, 0, 0, 1, 64'hA4A3A2A1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA4A3A2A1A0);
        add(0, 1, 8'hA5, 0, 0, 1, 64'hA5A4A3A2A1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA5A4A3A2A1A0);
        add(0, 1, 8'hA6, 0, 0, 1, 64'hA6A5A4A3A2A1A0);
        add(0, 0, 8'hEE, 0, 0, 1, 64'hA6A5A4A3A2A1A0);
        add(0, 1, 8'hA7, 0, 1, 0, 64'hA7A6A5A4A3A2A1A0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rdy);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ed);
`ifdef PACK_FLUSH_EN
            check($sformatf("vec%0d.count", i), {60'd0, count},
                  vecs[i].ev ? 64'd8 : 64'd0);
`endif
        end

        // Back-pressure: word held for 5 cycles while samples are offered.
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 8'h99, 0);
            check_out($sformatf("hold%0d", k), 1, 0, 64'hA7A6A5A4A3A2A1A0);
        end
        step(0, 1, 8'h99, 1);
        check_out("release", 0, 1, 64'h0);
        step(0, 1, 8'h42, 0);
        check_out("restart_lane0", 0, 1, 64'h42);
        step(0, 0, 8'h00, 0);

        // Narrow instance: 3 lanes of 4 bits, back-to-back words.
        step3(1, 0, 4'h0, 0);
        check_out3("n3_reset", 0, 1, 12'h000);
        step3(0, 1, 4'h1, 1);
        step3(0, 1, 4'h2, 1);
        check_out3("n3_partial", 0, 1, 12'h021);
        step3(0, 1, 4'h3, 1);
        check_out3("n3_word1", 1, 0, 12'h321);
        step3(0, 1, 4'h9, 1);
        check_out3("n3_clear", 0, 1, 12'h000);
        step3(0, 1, 4'h4, 1);
        step3(0, 1, 4'h5, 1);
        step3(0, 1, 4'h6, 0);
        check_out3("n3_word2", 1, 0, 12'h654);
        step3(0, 0, 4'h0, 1);
        check_out3("n3_clear2", 0, 1, 12'h000);

`ifdef PACK_FLUSH_EN
        // Flush together with the third sample closes a 3-lane word.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        @(negedge clock);
        reset = 0; valid_in = 1; data_in = 8'h33; ready_in = 0; flush = 1;
        @(posedge clock);
        #1;
        check_out("flush_word", 1, 0, 64'h0000000000332211);
        check("flush_count", {60'd0, count}, 64'd3);
        @(negedge clock);
        flush = 1; valid_in = 0; ready_in = 0;
        @(posedge clock);
        #1;
        check_out("flush_in_full", 1, 0, 64'h0000000000332211);
        check("flush_in_full_count", {60'd0, count}, 64'd3);
        step(0, 0, 8'h00, 1);
        check_out("flush_release", 0, 1, 64'h0);
        check("flush_release_count", {60'd0, count}, 64'd0);
        @(negedge clock);
        flush = 1; valid_in = 0; ready_in = 0;
        @(posedge clock);
        #1;
        check_out("flush_empty", 0, 1, 64'h0);
        @(negedge clock);
        flush = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
